mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator-side load/store controller for the multi-cycle CPU's data path. It sits between the CPU control unit's MEM stage and `Data_Memory`, and is the only block that drives `MemRead`, `MemWrite`, `DataAddr` and `writeData`. It performs byte, halfword and word accesses with sign or zero extension on loads. Sub-word stores are done as read-modify-write on the word-wide memory, and misaligned requests are rejected without touching memory.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `CLK`, in, 1: the only clock; all state changes on the rising edge.
- `RST_n`, in, 1: reset, asynchronous assert, active-low.
- `req`, in, 1: access request; sampled only in IDLE.
- `we`, in, 1: 1 = store, 0 = load.
- `size`, in, 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as misaligned.
- `sign_ext`, in, 1: on loads, 1 = sign-extend, 0 = zero-extend.
- `addr`, in, ADDR_W: byte address.
- `wdata`, in, 32: store data, right-aligned.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: valid with `done`; 1 = misaligned, and no memory access was made.
- `rdata`, out, 32: extended load result; holds until the next load completes.
- `DataAddr`, out, 32: word address `{addr[31:2],2'b00}` from the latched request.
- `MemRead`, out, 1: memory read strobe.
- `MemWrite`, out, 1: memory write strobe.
- `writeData`, out, 32: full word to memory.
- `readData`, in, 32: memory read data. Combinationally valid while `MemRead`=1 with `DataAddr` stable.

## Operation
Memory contract:
- `Data_Memory` commits `writeData` on the rising `CLK` edge that ends a cycle in which `MemWrite`=1.
- Lane mapping: byte offset k = `addr[1:0]` occupies bits [8k+7:8k].
- Halfword at offset 0 uses [15:0]; at offset 2 it uses [31:16].

Request handling:
- On `req`=1 in IDLE, latch `we`, `size`, `sign_ext`, `addr`, `wdata`.
- Misaligned means halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11.

States:
- IDLE: strobes low. Next state:
  - misaligned → DONE
  - load → RD
  - word store → WR
  - sub-word store → RD
- RD: `MemRead`=1. Capture `readData` into the internal word register `rword`.
  - load → DONE
  - store → WR
- WR: `MemWrite`=1.
  - `writeData` = latched `wdata` for a word store.
  - Otherwise `writeData` = `rword` with the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Next state: DONE.
- DONE: `done`=1. `err` = misaligned flag. On a successful load, `rdata` is updated from `rword`: select the lane, then sign- or zero-extend to 32 bits. Next state: IDLE.

Other rules:
- `MemRead` and `MemWrite` are never high in the same cycle.
- Both strobes are low in IDLE and DONE.
- `req` in any state other than IDLE is ignored, not queued.
- A misaligned request leaves `rdata` unchanged.

## Timing
Acceptance edge = edge E0, at which IDLE sees `req`=1. Latencies from E0:
- Load, any size: RD in cycle 1, `done` in cycle 2.
- Word store: WR in cycle 1 (commit at the end of cycle 1), `done` in cycle 2.
- Sub-word store: RD in cycle 1, WR in cycle 2, `done` in cycle 3.
- Misaligned: `done` and `err` in cycle 1. No strobes are asserted.

`busy` and `done`:
- `busy` rises in cycle 1 and stays high through DONE.
- A new `req` can be accepted at the edge ending DONE's successor cycle, i.e. the first IDLE cycle.

Reset values (`RST_n`=0, immediate, asynchronous):
- state = IDLE.
- `busy`, `done`, `err`, `MemRead`, `MemWrite` = 0.
- `rdata` = 0, `DataAddr` = 0, `writeData` = 0.

Reset during WR:
- `MemWrite` drops before the edge, so no commit occurs.
- After release the block is in IDLE. The first edge with `RST_n`=1 may accept `req`.

## Test plan
- Word store, then word load: store `addr`=8, `wdata`=0x11223344 → `MemWrite` high for exactly 1 cycle with `DataAddr`=8, `done` at E0+2. Load `addr`=8 → `rdata`=0x11223344 at E0+2.
- Byte store RMW: memory[8]=0x11223344, store byte `addr`=9, `wdata`=0xAB → RD then WR with `writeData`=0x1122AB44, `done` at E0+3. A word load then returns 0x1122AB44.
- Signed and unsigned sub-word loads from word 0x80F0_7FFF at address 12:
  - halfword `addr`=12, `sign_ext`=1 → 0x00007FFF
  - halfword `addr`=14, `sign_ext`=1 → 0xFFFF80F0
  - byte `addr`=15, `sign_ext`=0 → 0x00000080
  - byte `addr`=15, `sign_ext`=1 → 0xFFFFFF80
- Misalignment: word load `addr`=10 and halfword store `addr`=13 → `done`=`err`=1 at E0+1. `MemRead` and `MemWrite` stay 0, `rdata` is unchanged, and memory is unchanged.
- Busy rules: assert `req` continuously with different addresses → only the request sampled in IDLE executes. `req` during RD/WR/DONE has no effect. Back-to-back accepts are spaced by latency+1 cycles.
- Reset mid-store: start a halfword store to `addr`=16 and pull `RST_n` low in the WR cycle → all outputs are 0 immediately and word 16 is unchanged. After release, a word load from 16 returns the old value.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU MEM stage and a word-wide data memory.
// Handles byte/halfword/word accesses, sub-word stores as read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [31:0]       DataAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       writeData,
  input  logic [31:0]       readData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_mis;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rdata;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rword;
  logic              w_mis;
  logic              w_accept;
  logic [31:0]       w_daddr;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   load_extend = sext ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   load_extend = sext ? {{16{h[15]}}, h} : {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    store_merge = m;
  endfunction

  assign w_mis    = misaligned(size, addr[1:0]);
  assign w_accept = (r_state == S_IDLE) && req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) w_next = w_mis ? S_DONE : ((we && size == 2'b10) ? S_WR : S_RD);
      S_RD:   w_next = r_we ? S_WR : S_DONE;
      S_WR:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control state and values that must read zero out of reset
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_mis   <= 1'b0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mis  <= w_mis;
        r_addr <= addr;
      end
      // Load result is extended as it is captured so it is valid alongside done
      if (r_state == S_RD && !r_we)
        r_rdata <= load_extend(readData, r_size, r_addr[1:0], r_sext);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_we    <= we;
      r_size  <= size;
      r_sext  <= sign_ext;
      r_wdata <= wdata;
    end
    if (r_state == S_RD) r_rword <= readData;
  end

  always_comb begin
    w_daddr = '0;
    w_daddr[ADDR_W-1:2] = r_addr[ADDR_W-1:2];
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_mis;
  assign rdata     = r_rdata;
  assign DataAddr  = w_daddr;
  assign MemRead   = (r_state == S_RD);
  assign MemWrite  = (r_state == S_WR);
  assign writeData = (r_state == S_WR) ? store_merge(r_rword, r_wdata, r_size, r_addr[1:0]) : 32'h0;

endmodule
